// File: rtl/ibex_dmem_responder_if.sv
// -----------------------------------------------------------------------------
// ibex_dmem_responder_if
//
// Ibex data-side LSU bus, bundled for the SRAM responder. The LSU (or a bench
// standing in for it) uses the master modport. The memory uses the slave
// modport.
//
// Signals (direction as seen by the master):
//   data_req    out  1   request valid
//   data_gnt    in   1   request accepted this cycle (combinational in slave)
//   data_we     out  1   1 = write, 0 = read
//   data_be     out  4   byte enables, bit i selects wdata[8i+7:8i]
//   data_addr   out  32  byte address, bits [1:0] ignored
//   data_wdata  out  32  write data
//   data_rvalid in   1   response valid, one cycle per granted request
//   data_rdata  in   32  read data, 0 for writes and errored accesses
//   data_err    in   1   access error, meaningful only with data_rvalid
// -----------------------------------------------------------------------------
interface ibex_dmem_responder_if;
  logic        data_req;
  logic        data_gnt;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_err;

  modport master (
    output data_req,
    output data_we,
    output data_be,
    output data_addr,
    output data_wdata,
    input  data_gnt,
    input  data_rvalid,
    input  data_rdata,
    input  data_err
  );

  modport slave (
    input  data_req,
    input  data_we,
    input  data_be,
    input  data_addr,
    input  data_wdata,
    output data_gnt,
    output data_rvalid,
    output data_rdata,
    output data_err
  );
endinterface

// File: rtl/ibex_dmem_responder.sv
// -----------------------------------------------------------------------------
// ibex_dmem_responder
//
// Single-port SRAM at the memory end of the Ibex LSU request/response
// protocol. Requests are granted while the number of granted-but-unanswered
// requests is below MaxOutstanding, or when a response retires in the same
// cycle. The memory is accessed at the grant edge. Responses come back in
// grant order exactly RespLatency cycles after the grant.
//
// Parameters:
//   MemWords        memory depth in 32-bit words (power of two, >= 2)
//   BaseAddr        byte address of word 0 (aligned to MemWords*4)
//   RespLatency     grant-to-rvalid latency in cycles (1..4)
//   MaxOutstanding  maximum in-flight requests (1..4)
//
// Ports:
//   clk_i   in   clock
//   rst_ni  in   asynchronous active-low reset. It clears the counter and
//                the response pipeline. Memory contents are not reset.
//   bus     slave modport of ibex_dmem_responder_if (req/gnt/we/be/addr/
//           wdata in, rvalid/rdata/err out)
//
// Build option:
//   IBEX_DMEM_RANGE_ERR_EN  When defined, accesses outside
//                           [BaseAddr, BaseAddr+MemWords*4) are still
//                           granted. Their writes are dropped, and they
//                           respond with err=1 and rdata=0.
//                           When undefined, such addresses alias onto the
//                           low index bits and err is always 0.
// -----------------------------------------------------------------------------
module ibex_dmem_responder #(
  parameter int unsigned MemWords       = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0010_0000,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  ibex_dmem_responder_if.slave bus
);

  localparam int unsigned IdxW = $clog2(MemWords);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  // ---------------------------------------------------------------------------
  // Outstanding counter and grant
  // ---------------------------------------------------------------------------
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            gnt;
  logic            rvalid_out;

  // A response leaving the pipeline this cycle frees its slot immediately.
  // This lets a full responder keep granting one request per cycle.
  assign gnt          = bus.data_req & ((cnt_q < CntW'(MaxOutstanding)) | rvalid_out);
  assign bus.data_gnt = gnt;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({gnt, rvalid_out})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;  // idle, or grant and retire cancel out
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [31:0]     offset;
  logic [IdxW-1:0] idx;
  logic            in_range;

  assign offset = bus.data_addr - BaseAddr;
  // Because BaseAddr is aligned to the memory size, the low index bits of the
  // offset are the same as those of the address. That gives the aliasing
  // behaviour for free when the range check is absent.
  assign idx    = offset[IdxW+1:2];

`ifdef IBEX_DMEM_RANGE_ERR_EN
  localparam logic [32:0] MemBytes = 33'(MemWords) << 2;
  // The subtraction wraps, so addresses below BaseAddr become huge offsets.
  // One unsigned compare therefore covers both ends of the window.
  assign in_range = ({1'b0, offset} < MemBytes);
`else
  assign in_range = 1'b1;
`endif

  // Offset bits that select nothing once the word index is taken.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{offset[31:IdxW+2], offset[1:0]};

  // ---------------------------------------------------------------------------
  // Memory: one byte-wide array per lane, so each byte enable maps directly
  // onto a lane write enable. Read data is registered at the grant edge.
  // ---------------------------------------------------------------------------
  logic        wr_en;
  logic        rd_en;
  logic [31:0] mem_rdata;

  assign wr_en = gnt & bus.data_we & in_range;
  assign rd_en = gnt & ~bus.data_we;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem_q [MemWords];
    logic [7:0] lane_rdata_q;

    always_ff @(posedge clk_i) begin
      if (wr_en && bus.data_be[gi]) begin
        lane_mem_q[idx] <= bus.data_wdata[8*gi +: 8];
      end
      if (rd_en) begin
        lane_rdata_q <= lane_mem_q[idx];
      end
    end

    assign mem_rdata[8*gi +: 8] = lane_rdata_q;
  end

  // ---------------------------------------------------------------------------
  // Response pipeline
  // Stage 0 is the cycle after the grant. Its data comes straight from the
  // memory read register and is masked by a flag recording whether the access
  // was a successful read. Later stages are plain shift registers.
  // ---------------------------------------------------------------------------
  logic s0_valid_q;
  logic s0_rd_q;
  logic s0_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s0_valid_q <= 1'b0;
      s0_rd_q    <= 1'b0;
      s0_err_q   <= 1'b0;
    end else begin
      s0_valid_q <= gnt;
      s0_rd_q    <= rd_en & in_range;
      s0_err_q   <= gnt & ~in_range;
    end
  end

  logic        st_valid [RespLatency];
  logic [31:0] st_rdata [RespLatency];
  logic        st_err   [RespLatency];

  assign st_valid[0] = s0_valid_q;
  assign st_rdata[0] = s0_rd_q ? mem_rdata : 32'h0;
  assign st_err[0]   = s0_err_q;

  for (genvar gi = 1; gi < RespLatency; gi++) begin : g_stage
    logic        valid_q;
    logic [31:0] rdata_q;
    logic        err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= 1'b0;
        rdata_q <= 32'h0;
        err_q   <= 1'b0;
      end else begin
        valid_q <= st_valid[gi-1];
        rdata_q <= st_rdata[gi-1];
        err_q   <= st_err[gi-1];
      end
    end

    assign st_valid[gi] = valid_q;
    assign st_rdata[gi] = rdata_q;
    assign st_err[gi]   = err_q;
  end

  assign rvalid_out      = st_valid[RespLatency-1];
  assign bus.data_rvalid = rvalid_out;
  assign bus.data_rdata  = st_rdata[RespLatency-1];
  assign bus.data_err    = st_err[RespLatency-1];

endmodule

// File: tb/tb_ibex_dmem_responder.sv
`timescale 1ns/1ps
module tb_ibex_dmem_responder;

  localparam logic [31:0] BA  = 32'h0010_0000;
  localparam int          L0  = 1;
  localparam int          MO0 = 2;
  localparam int          L1  = 3;
  localparam int          MO1 = 2;

`ifdef IBEX_DMEM_RANGE_ERR_EN
  localparam bit RangeErr = 1'b1;
`else
  localparam bit RangeErr = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, rst1_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ibex_dmem_responder_if bus0();
  ibex_dmem_responder_if bus1();

  // dut0: default latency, 1 KiW memory. dut1: latency 3, 16 words, back-pressured.
  ibex_dmem_responder #(.MemWords(1024), .BaseAddr(BA), .RespLatency(L0), .MaxOutstanding(MO0))
    u_dut0 (.clk_i(clk), .rst_ni(rst0_n), .bus(bus0.slave));
  ibex_dmem_responder #(.MemWords(16), .BaseAddr(BA), .RespLatency(L1), .MaxOutstanding(MO1))
    u_dut1 (.clk_i(clk), .rst_ni(rst1_n), .bus(bus1.slave));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_push [2];
  int   n_pop  [2];
  int   n_drop [2];
  int   mcnt   [2];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Per-cycle monitor: checks grant against an independent outstanding count,
  // and pops the scoreboard on every response.
  task automatic mon(input int id, input logic rstn, input logic req, input logic gnt,
                     input logic rv, input logic [31:0] rd, input logic er);
    exp_t e;
    bit   have;
    bit   exp_g;
    int   mo;
    mo = (id == 0) ? MO0 : MO1;
    if (!rstn) begin
      if (id == 0) begin n_drop[0] += q0.size(); q0.delete(); end
      else         begin n_drop[1] += q1.size(); q1.delete(); end
      mcnt[id] = 0;
      chk($sformatf("dut%0d_rst_rvalid", id), 32'(rv), 32'h0);
      chk($sformatf("dut%0d_rst_rdata", id), rd, 32'h0);
      chk($sformatf("dut%0d_rst_err", id), 32'(er), 32'h0);
      return;
    end
    exp_g = req && ((mcnt[id] < mo) || rv);
    chk($sformatf("dut%0d_gnt", id), 32'(gnt), 32'(exp_g));
    have = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) e = (id == 0) ? q0[0] : q1[0];
    if (rv) begin
      if (!have) begin
        chk($sformatf("dut%0d_spurious_rvalid", id), 32'h1, 32'h0);
      end else begin
        if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        n_pop[id]++;
        chk($sformatf("dut%0d_rdata", id), rd, e.rdata);
        chk($sformatf("dut%0d_err", id), 32'(er), 32'(e.err));
        chk($sformatf("dut%0d_rsp_cycle", id), 32'(cyc), 32'(e.due));
        $display("[%0d] dut%0d rsp rdata=%h err=%b", cyc, id, rd, er);
      end
    end else if (have && e.due <= cyc) begin
      chk($sformatf("dut%0d_missing_rvalid", id), 32'h0, 32'h1);
      if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
    mcnt[id] = mcnt[id] + (exp_g ? 1 : 0) - (rv ? 1 : 0);
    if (mcnt[id] < 0) mcnt[id] = 0;
  endtask

  always @(negedge clk) mon(0, rst0_n, bus0.data_req, bus0.data_gnt, bus0.data_rvalid,
                            bus0.data_rdata, bus0.data_err);
  always @(negedge clk) mon(1, rst1_n, bus1.data_req, bus1.data_gnt, bus1.data_rvalid,
                            bus1.data_rdata, bus1.data_err);

  task automatic drive(input int id, input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (id == 0) begin
      bus0.data_req = req; bus0.data_we = we; bus0.data_be = be;
      bus0.data_addr = addr; bus0.data_wdata = wd;
    end else begin
      bus1.data_req = req; bus1.data_we = we; bus1.data_be = be;
      bus1.data_addr = addr; bus1.data_wdata = wd;
    end
  endtask

  task automatic idle(input int id);
    drive(id, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Holds the request until granted (bounded), pushes the expected response on
  // the grant, and returns just after the following clock edge.
  task automatic issue(input int id, input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] ed, input logic ee, output int gc);
    exp_t e;
    logic g;
    int   lat;
    lat = (id == 0) ? L0 : L1;
    drive(id, 1'b1, we, be, addr, wd);
    gc = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); #1;
      g = (id == 0) ? bus0.data_gnt : bus1.data_gnt;
      if (g) begin
        gc = cyc;
        e.rdata = ed; e.err = ee; e.due = cyc + lat;
        if (id == 0) q0.push_back(e); else q1.push_back(e);
        n_push[id]++;
      end
      @(posedge clk); #1;
      if (gc >= 0) break;
    end
    if (gc < 0) chk($sformatf("dut%0d_grant_timeout", id), 32'h0, 32'h1);
    $display("[%0d] dut%0d req %s addr=%h be=%h wdata=%h granted@%0d", cyc, id,
             we ? "W" : "R", addr, be, wd, gc);
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t        tv [16];
  logic [31:0] m0 [8];
  int          bp_exp [6];
  int          gc, prev_gc, start, first_gc;

  initial begin
    // Directed vectors for dut0, back-to-back.
    tv[0]  = '{1'b1, 4'hF, BA + 32'h8,    32'hDEAD_BEEF, 32'h0,         1'b0};
    tv[1]  = '{1'b0, 4'hF, BA + 32'h8,    32'h0,         32'hDEAD_BEEF, 1'b0};
    tv[2]  = '{1'b1, 4'hF, BA + 32'hC,    32'h1122_3344, 32'h0,         1'b0};
    tv[3]  = '{1'b1, 4'h5, BA + 32'hC,    32'hAABB_CCDD, 32'h0,         1'b0};
    tv[4]  = '{1'b0, 4'hF, BA + 32'hC,    32'h0,         32'h11BB_33DD, 1'b0};
    tv[5]  = '{1'b1, 4'hF, BA,            32'hCAFE_F00D, 32'h0,         1'b0};
    tv[6]  = '{1'b0, 4'hF, BA + 32'h1000, 32'h0,
               RangeErr ? 32'h0 : 32'hCAFE_F00D, RangeErr};
    tv[7]  = '{1'b1, 4'hF, BA + 32'h1000, 32'h1234_5678, 32'h0,         RangeErr};
    tv[8]  = '{1'b0, 4'hF, BA,            32'h0,
               RangeErr ? 32'hCAFE_F00D : 32'h1234_5678, 1'b0};
    tv[9]  = '{1'b1, 4'hF, BA + 32'hFFC,  32'h0F0F_0F0F, 32'h0,         1'b0};
    tv[10] = '{1'b0, 4'hF, BA + 32'hFFE,  32'h0,         32'h0F0F_0F0F, 1'b0};
    tv[11] = '{1'b0, 4'hF, BA - 32'h4,    32'h0,
               RangeErr ? 32'h0 : 32'h0F0F_0F0F, RangeErr};
    tv[12] = '{1'b1, 4'h0, BA + 32'h8,    32'hFFFF_FFFF, 32'h0,         1'b0};
    tv[13] = '{1'b1, 4'h8, BA + 32'h9,    32'h5500_0000, 32'h0,         1'b0};
    tv[14] = '{1'b0, 4'hF, BA + 32'h8,    32'h0,         32'h55AD_BEEF, 1'b0};
    tv[15] = '{1'b0, 4'hF, BA + 32'hC,    32'h0,         32'h11BB_33DD, 1'b0};
    bp_exp[0] = 0; bp_exp[1] = 1; bp_exp[2] = 3; bp_exp[3] = 4; bp_exp[4] = 6; bp_exp[5] = 7;
    for (int i = 0; i < 2; i++) begin n_push[i] = 0; n_pop[i] = 0; n_drop[i] = 0; mcnt[i] = 0; end

    rst0_n = 1'b0; rst1_n = 1'b0;
    idle(0); idle(1);
    repeat (3) @(posedge clk);
    #1;
    rst0_n = 1'b1; rst1_n = 1'b1;

    // Directed table on dut0: grant must not drop with MaxOutstanding >= latency.
    start = cyc;
    prev_gc = 0;
    for (int i = 0; i < 16; i++) begin
      issue(0, tv[i].we, tv[i].be, tv[i].addr, tv[i].wdata, tv[i].exp_rdata, tv[i].exp_err, gc);
      if (i == 0) chk("dut0_first_gnt_after_reset", 32'(gc), 32'(start));
      else        chk("dut0_back_to_back_gnt", 32'(gc - prev_gc), 32'h1);
      prev_gc = gc;
    end
    idle(0);

    // Randomised byte-enable traffic on dut0 against a small memory model.
    for (int i = 0; i < 8; i++) begin
      m0[i] = $urandom;
      issue(0, 1'b1, 4'hF, BA + 32'((16 + i) * 4), m0[i], 32'h0, 1'b0, gc);
    end
    for (int i = 0; i < 40; i++) begin
      int          w;
      logic        wr;
      logic [3:0]  bee;
      logic [31:0] wd, ed;
      w   = $urandom_range(0, 7);
      wr  = 1'($urandom_range(0, 1));
      bee = 4'($urandom);
      wd  = $urandom;
      ed  = 32'h0;
      if (wr) begin
        for (int b = 0; b < 4; b++) if (bee[b]) m0[w][8*b +: 8] = wd[8*b +: 8];
      end else begin
        ed = m0[w];
      end
      issue(0, wr, bee, BA + 32'((16 + w) * 4) + 32'($urandom_range(0, 3)), wd, ed, 1'b0, gc);
      if ($urandom_range(0, 1) == 1) begin idle(0); @(posedge clk); #1; end
    end
    idle(0);

    // dut1: fill words 0..5, writes themselves see back-pressure.
    for (int i = 0; i < 6; i++)
      issue(1, 1'b1, 4'hF, BA + 32'(i * 4), 32'hA5A5_0000 + 32'(i), 32'h0, 1'b0, gc);
    idle(1);
    repeat (6) @(posedge clk);
    #1;

    // Back-pressure: six reads with req held high, grants at 0,1,3,4,6,7.
    first_gc = 0;
    for (int i = 0; i < 6; i++) begin
      issue(1, 1'b0, 4'hF, BA + 32'(i * 4), 32'h0, 32'hA5A5_0000 + 32'(i), 1'b0, gc);
      if (i == 0) first_gc = gc;
      chk("dut1_bp_grant_offset", 32'(gc - first_gc), 32'(bp_exp[i]));
    end
    idle(1);
    repeat (6) @(posedge clk);
    #1;

    // Reset mid-flight: two reads granted, reset in the cycle before the first rvalid.
    issue(1, 1'b0, 4'hF, BA + 32'h4, 32'h0, 32'hA5A5_0001, 1'b0, gc);
    issue(1, 1'b0, 4'hF, BA + 32'h8, 32'h0, 32'hA5A5_0002, 1'b0, gc);
    idle(1);
    rst1_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst1_n = 1'b1;
    chk("dut1_dropped_in_reset", 32'(n_drop[1]), 32'h2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("dut1_no_rvalid_after_reset", 32'(bus1.data_rvalid), 32'h0);
    end
    @(posedge clk); #1;
    start = cyc;
    issue(1, 1'b0, 4'hF, BA + 32'hC, 32'h0, 32'hA5A5_0003, 1'b0, gc);
    chk("dut1_gnt_immediately_after_reset", 32'(gc), 32'(start));
    issue(1, 1'b0, 4'hF, BA, 32'h0, 32'hA5A5_0000, 1'b0, gc);
    chk("dut1_second_gnt_after_reset", 32'(gc), 32'(start + 1));
    idle(1);

    repeat (10) @(posedge clk);
    #1;
    chk("dut0_queue_empty", 32'(q0.size()), 32'h0);
    chk("dut1_queue_empty", 32'(q1.size()), 32'h0);
    chk("dut0_resp_count", 32'(n_pop[0]), 32'(n_push[0] - n_drop[0]));
    chk("dut1_resp_count", 32'(n_pop[1]), 32'(n_push[1] - n_drop[1]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule
